// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed seven-segment display path.
package display_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  localparam seg_t                  SEG_BLANK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;

  // Active-low one-hot enable for the selected digit.
  function automatic logic [NUM_DIGITS-1:0] digit_anode(input logic [2:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low {g,f,e,d,c,b,a} segment decoder.
module hex_to_seg
  import display_pkg::*;
(
  input  nibble_t nib,
  output seg_t    seg
);

  always_comb begin
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/hex_display_scan.sv
// Scans a once-per-frame snapshot of a 32-bit word onto an 8-digit common-anode display.
// Define HEX_DISPLAY_LZ_BLANK_EN to blank leading-zero digits (digit 0 always lit).
module hex_display_scan
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           q_in,
  input  logic                  freeze,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            cathode
);

  localparam int               DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [2:0]            dig_q, dig_d;
  logic [31:0]           snap_q, snap_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  seg_t                  cathode_q, cathode_d;

  logic    tick;
  logic    blank;
  nibble_t nib;
  seg_t    seg;

  assign tick = (div_cnt_q == DIV_LAST);
  assign nib  = snap_q[{dig_q, 2'b00} +: 4];

`ifdef HEX_DISPLAY_LZ_BLANK_EN
  logic [31:0] upper;
  assign upper = snap_q >> {dig_q, 2'b00};
  assign blank = (dig_q != 3'd0) && (upper == 32'd0);
`else
  assign blank = 1'b0;
`endif

  hex_to_seg u_hex_to_seg (
    .nib (nib),
    .seg (seg)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    div_cnt_d = div_cnt_q + DIV_W'(1);
    dig_d     = dig_q;
    snap_d    = snap_q;
    anode_d   = digit_anode(dig_q);
    cathode_d = seg;

    if (tick) begin
      div_cnt_d = '0;
      dig_d     = dig_q + 3'd1;
      // Frame boundary: the only moment q_in and freeze are looked at.
      if (dig_q == 3'd7 && !freeze) begin
        snap_d = q_in;
      end
    end

    if (blank) begin
      anode_d   = ANODE_OFF;
      cathode_d = SEG_BLANK;
    end
  end

  // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      dig_q     <= '0;
      snap_q    <= '0;
      anode_q   <= ANODE_OFF;
      cathode_q <= SEG_BLANK;
    end else begin
      div_cnt_q <= div_cnt_d;
      dig_q     <= dig_d;
      snap_q    <= snap_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed self-checking bench for hex_display_scan with REFRESH_DIV=4.
module tb_hex_display_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] q_in;
  logic        freeze;
  logic [7:0]  anode;
  logic [6:0]  cathode;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hex_display_scan #(.REFRESH_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .q_in    (q_in),
    .freeze  (freeze),
    .anode   (anode),
    .cathode (cathode)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    logic [6:0] table_v [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return table_v[n];
  endfunction

  function automatic logic is_blank(input int d, input logic [31:0] s);
`ifdef HEX_DISPLAY_LZ_BLANK_EN
    return (d != 0) && ((s >> (4 * d)) == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Walk `count` digit slots starting at `first`, checking every cycle of each slot.
  task automatic run_digits(input int first, input int count, input logic [31:0] s);
    for (int d = first; d < first + count; d++) begin
      for (int c = 0; c < 4; c++) begin
        logic [7:0] ea;
        logic [6:0] ec;
        @(posedge clk);
        @(negedge clk);
        ea = is_blank(d, s) ? 8'hFF : ~(8'b1 << d);
        ec = is_blank(d, s) ? 7'h7F : hex_seg(s[4*d +: 4]);
        check($sformatf("anode s=%h d%0d c%0d", s, d, c), {24'd0, anode}, {24'd0, ea});
        check($sformatf("cathode s=%h d%0d c%0d", s, d, c), {25'd0, cathode}, {25'd0, ec});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    q_in   = 32'd0;
    freeze = 1'b0;
    repeat (3) @(negedge clk);
    check("reset anode", {24'd0, anode}, 32'hFF);
    check("reset cathode", {25'd0, cathode}, 32'h7F);

    // Frame 0 shows the reset snapshot; its last edge captures 1234ABCD.
    q_in = 32'h1234ABCD;
    rst  = 1'b0;
    run_digits(0, 8, 32'h0);

    // Mid-frame q_in change is ignored until the next boundary.
    run_digits(0, 3, 32'h1234ABCD);
    q_in = 32'hFFFFFFFF;
    run_digits(3, 5, 32'h1234ABCD);
    q_in = 32'h1234ABCD;
    run_digits(0, 8, 32'hFFFFFFFF);

    // Freeze across one boundary holds the snapshot.
    freeze = 1'b1;
    q_in   = 32'h0;
    run_digits(0, 8, 32'h1234ABCD);
    freeze = 1'b0;
    run_digits(0, 8, 32'h1234ABCD);

    q_in = 32'h000000A5;
    run_digits(0, 8, 32'h0);
    run_digits(0, 3, 32'h000000A5);

    // Asynchronous reset mid-scan, observed before the next clock edge.
    #2 rst = 1'b1;
    #1;
    check("async reset anode", {24'd0, anode}, 32'hFF);
    check("async reset cathode", {25'd0, cathode}, 32'h7F);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_digits(0, 8, 32'h0);
    run_digits(0, 8, 32'h000000A5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hex_display_scan.md
# hex_display_scan

Read-side consumer of a 32-bit load register. It takes the register's `q` value and shows it as eight hex digits on a common-anode, time-multiplexed seven-segment display. A value is captured once per display frame, so all eight digits within a frame show one consistent word. The block sits between the register bank output and the board display pins.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000. Clock cycles per digit slot (100 MHz gives 1 kHz per digit). Legal range is 1 or more.

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `q_in`  input  32  register value to display.
- `freeze`  input  1  while high, frame-boundary capture is suppressed and the displayed value holds.
- `anode`  output  8  digit enables, active-low. Bit k selects digit k; digit 0 is the rightmost, showing nibble [3:0].
- `cathode`  output  7  segments, active-low, ordered {g,f,e,d,c,b,a}.

## Operation
State:
- Prescaler `div_cnt`, width max(1, clog2(REFRESH_DIV)).
- Digit index `dig` (3 bits).
- Snapshot register `snap` (32 bits).

Tick and digit advance:
- `tick` is asserted when `div_cnt == REFRESH_DIV-1`. On tick, `div_cnt` returns to 0; otherwise it increments.
- With `REFRESH_DIV == 1`, tick is asserted every cycle.
- On tick, `dig` increments and wraps from 7 to 0.

Capture:
- A frame boundary is a tick while `dig == 7`.
- At a frame boundary, `snap <= q_in` if `freeze == 0`. If `freeze == 1`, `snap` holds.
- `q_in` changes at any other time have no effect.

Outputs (registered every cycle from current state):
- `anode <= ~(8'b1 << dig)`.
- `cathode <= hex7(snap[4*dig +: 4])`.

Hex encoding, all values active-low {g..a}:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110

Reset (asynchronous, takes effect immediately, including mid-frame):
- `div_cnt=0`, `dig=0`, `snap=0`.
- `anode=8'hFF` (all digits off), `cathode=7'h7F` (all segments off).
- After release, scanning restarts at digit 0 with `snap=0`. The first real capture happens at the first frame boundary.

## Timing
- Outputs lag `dig` and `snap` by exactly one clock.
- Each digit is lit for exactly REFRESH_DIV cycles. A frame is 8·REFRESH_DIV cycles.
- First clock edge after reset release: `anode=8'hFE`, `cathode=7'b1000000`.
- Capture-to-display latency: the new digit 0 appears 1 cycle after the frame-boundary edge.
- `freeze` is sampled only at the frame-boundary edge.

## Configuration
Macro `HEX_DISPLAY_LZ_BLANK_EN` controls leading-zero blanking.
- Defined: digit k (k ≥ 1) is blanked if `snap[31:4k] == 0`. A blanked digit drives `anode[k]=1` and `cathode=7'h7F`. Digit 0 is never blanked. Slot timing is unchanged; blanked slots stay dark for their full REFRESH_DIV cycles.
- Undefined: all eight digits are always driven, including leading zeros.

## Structure
Shared package `display_pkg` holds:
- `NUM_DIGITS=8`
- `SEG_BLANK=7'h7F`
- `ANODE_OFF=8'hFF`
- the 4-bit nibble and 7-bit segment typedefs

Sub-module `hex_to_seg` is a purely combinational nibble-to-segment decoder with input `nib[3:0]` and output `seg[6:0]`, instantiated once. Everything else lives in the top module.

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset: `rst` high mid-scan gives `anode=FF` and `cathode=7F` immediately, before any clock edge. On release, the first edge gives `anode=FE`, `cathode=1000000`.
- Scan rate: `anode` steps FE→FD→FB→…→7F→FE. Each value is held exactly 4 cycles, and the frame period is 32 cycles.
- Capture: hold `q_in=32'h1234ABCD` through a frame boundary. The next frame shows digit 0 `cathode=0100001` ('d') and digit 7 `cathode=1111001` ('1'). Changing `q_in` to `32'hFFFFFFFF` at digit 3 causes no change until the following frame.
- Freeze: `freeze=1` across a boundary with `q_in=32'h0` keeps showing `1234ABCD`. After `freeze=0` and the next boundary, all digits show '0'.
- Blanking, macro defined: `q_in=32'h000000A5` gives digit 0 '5' (0010010), digit 1 'A' (0001000), and digits 2–7 with `anode` high and `cathode=7F`. With `q_in=0`, only digit 0 lights, showing '0'.
- Blanking, macro undefined: the same `q_in=32'h000000A5` lights all eight digits, with digits 2–7 showing '0'.
